// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Round-robin message scheduler that shares one byte-level UART transmitter
// between NUM_REQ requesters. A requester is granted for a whole message,
// from its first byte to its last byte. Its bytes are passed straight through
// to the transmitter using a valid/ready handshake. After each message a
// fixed idle gap is enforced. Messages longer than MAX_BYTES are cut, and the
// remaining bytes are sent as a new message on a later grant.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   GAP_CYCLES  idle clk cycles after each message (0 = no gap)
//   MAX_BYTES   maximum bytes per message before truncation (1..65535)
//   IDX_W       width of the grant index
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset, sampled on posedge clk
//   req_valid  per-requester byte valid
//   req_data   per-requester byte; requester i uses bits [8*i+7:8*i]
//   req_last   final byte of a message, qualified by req_valid
//   req_ready  per-requester byte accept (only the grantee can be high)
//   tx_data    byte to the UART transmitter
//   tx_valid   byte valid to the transmitter
//   tx_ready   transmitter accepts the byte
//   busy       high in ARB, XFER and GAP
//   grant_id   index of the current or most recent grantee
//   msg_count  completed or truncated messages, wraps to 0
//   trunc_stb  one-cycle pulse after a message is truncated
// -----------------------------------------------------------------------------
module uart_tx_sched #(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 16,
   parameter int MAX_BYTES  = 64,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic [IDX_W-1:0]       grant_id,
   output logic [15:0]            msg_count,
   output logic                   trunc_stb
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARB,
      S_XFER,
      S_GAP
   } state_e;

   // After a message ends, skip the gap state entirely when no gap is wanted.
   localparam state_e END_STATE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

   state_e           state_q;
   logic [IDX_W-1:0] grant_q;
   logic [IDX_W-1:0] last_grant_q;
   logic [15:0]      byte_cnt_q;
   logic [15:0]      gap_cnt_q;
   logic [15:0]      msg_count_q;
   logic             trunc_q;

   // Round-robin winner, searched from last_grant+1 upward with wrap.
   logic [IDX_W-1:0] win_idx_d;
   logic             win_found_d;
   logic [IDX_W-1:0] cand;

   // Signals of the currently granted requester.
   logic             sel_valid;
   logic             sel_last;
   logic [7:0]       sel_data;
   logic             handshake;
   logic             max_hit;

   // NOTE: every variable assigned in an always_comb gets a default at the
   // top of the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      win_found_d = 1'b0;
      win_idx_d   = '0;
      cand        = last_grant_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
         if (!win_found_d && req_valid[cand]) begin
            win_found_d = 1'b1;
            win_idx_d   = cand;
         end
      end
   end

   // Combinational passthrough of the grantee while in XFER.
   always_comb begin
      sel_valid = req_valid[grant_q];
      sel_last  = req_last[grant_q];
      sel_data  = req_data[{grant_q, 3'b000} +: 8];
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      if (state_q == S_XFER) begin
         tx_valid           = sel_valid;
         tx_data            = sel_data;
         req_ready[grant_q] = tx_ready;
      end
   end

   assign handshake = (state_q == S_XFER) && sel_valid && tx_ready;
   // The byte being accepted is the MAX_BYTES-th of this message.
   assign max_hit   = (byte_cnt_q == 16'(MAX_BYTES - 1));

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         byte_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         msg_count_q  <= '0;
         trunc_q      <= 1'b0;
      end else begin
         trunc_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|req_valid) begin
                  state_q <= S_ARB;
               end
            end

            S_ARB: begin
               if (win_found_d) begin
                  grant_q      <= win_idx_d;
                  last_grant_q <= win_idx_d;
                  byte_cnt_q   <= '0;
                  state_q      <= S_XFER;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_XFER: begin
               // A stalled grantee keeps the grant; only a handshake advances.
               if (handshake) begin
                  byte_cnt_q <= byte_cnt_q + 16'd1;
                  if (sel_last || max_hit) begin
                     // When last and the length limit coincide, the message
                     // ended naturally and is not reported as truncated.
                     trunc_q     <= !sel_last;
                     msg_count_q <= msg_count_q + 16'd1;
                     gap_cnt_q   <= '0;
                     state_q     <= END_STATE;
                  end
               end
            end

            S_GAP: begin
               if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
                  gap_cnt_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign grant_id  = grant_q;
   assign msg_count = msg_count_q;
   assign trunc_stb = trunc_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched. Three instances share one stimulus:
//   u_dut   default parameters (GAP_CYCLES=16, MAX_BYTES=64)
//   u_trunc MAX_BYTES=4
//   u_nogap GAP_CYCLES=0
// Each phase checks the instance whose parameters it targets.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic        tx_ready;

   logic [3:0]  d0_req_ready, d1_req_ready, d2_req_ready;
   logic [7:0]  d0_tx_data, d1_tx_data, d2_tx_data;
   logic        d0_tx_valid, d1_tx_valid, d2_tx_valid;
   logic        d0_busy, d1_busy, d2_busy;
   logic [1:0]  d0_grant_id, d1_grant_id, d2_grant_id;
   logic [15:0] d0_msg_count, d1_msg_count, d2_msg_count;
   logic        d0_trunc_stb, d1_trunc_stb, d2_trunc_stb;

   int n_checks = 0;
   int n_err    = 0;
   int exp_g[5];

   always #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(16), .MAX_BYTES(64)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(d0_req_ready), .tx_data(d0_tx_data), .tx_valid(d0_tx_valid),
      .tx_ready(tx_ready), .busy(d0_busy), .grant_id(d0_grant_id),
      .msg_count(d0_msg_count), .trunc_stb(d0_trunc_stb)
   );

   uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(16), .MAX_BYTES(4)) u_trunc (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(d1_req_ready), .tx_data(d1_tx_data), .tx_valid(d1_tx_valid),
      .tx_ready(tx_ready), .busy(d1_busy), .grant_id(d1_grant_id),
      .msg_count(d1_msg_count), .trunc_stb(d1_trunc_stb)
   );

   uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(0), .MAX_BYTES(64)) u_nogap (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(d2_req_ready), .tx_data(d2_tx_data), .tx_valid(d2_tx_valid),
      .tx_ready(tx_ready), .busy(d2_busy), .grant_id(d2_grant_id),
      .msg_count(d2_msg_count), .trunc_stb(d2_trunc_stb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_ready  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic tx_v(input int sel);
      case (sel)
         0:       return d0_tx_valid;
         1:       return d1_tx_valid;
         default: return d2_tx_valid;
      endcase
   endfunction

   // Bounded wait for the selected instance to present a byte.
   task automatic wait_tx(input int sel, input string tag);
      int c = 0;
      while (!tx_v(sel) && c < 60) begin
         tick();
         c++;
      end
      check(tag, 32'(tx_v(sel)), 32'd1);
   endtask

   // At most one requester may see req_ready at any time.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("ready_onehot",
               32'(($countones(d0_req_ready) <= 1) &&
                   ($countones(d1_req_ready) <= 1) &&
                   ($countones(d2_req_ready) <= 1)), 32'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_g = '{0, 1, 2, 3, 0};

      // ---------------- reset state ----------------
      do_reset();
      check("rst_busy",  32'(d0_busy), 32'd0);
      check("rst_txv",   32'(d0_tx_valid), 32'd0);
      check("rst_rdy",   32'(d0_req_ready), 32'd0);
      check("rst_msg",   32'(d0_msg_count), 32'd0);
      check("rst_grant", 32'(d0_grant_id), 32'd0);
      check("rst_trunc", 32'(d0_trunc_stb), 32'd0);

      // ---------------- single 3-byte message from requester 0 ----------------
      tx_ready       = 1'b1;
      req_valid      = 4'b0001;
      req_data[7:0]  = 8'h48;
      tick();                                   // IDLE -> ARB
      check("t1_arb_busy", 32'(d0_busy), 32'd1);
      check("t1_arb_txv",  32'(d0_tx_valid), 32'd0);
      tick();                                   // ARB -> XFER
      check("t1_txv",   32'(d0_tx_valid), 32'd1);
      check("t1_b0",    32'(d0_tx_data), 32'h48);
      check("t1_grant", 32'(d0_grant_id), 32'd0);
      check("t1_rdy",   32'(d0_req_ready), 32'b0001);
      tick();
      req_data[7:0] = 8'h69;
      #1;
      check("t1_b1", 32'(d0_tx_data), 32'h69);
      tick();
      req_data[7:0] = 8'h0A;
      req_last      = 4'b0001;
      #1;
      check("t1_b2", 32'(d0_tx_data), 32'h0A);
      tick();                                   // last handshake -> GAP
      req_valid = '0;
      req_last  = '0;
      check("t1_msg",      32'(d0_msg_count), 32'd1);
      check("t1_gap_busy", 32'(d0_busy), 32'd1);
      check("t1_gap_txv",  32'(d0_tx_valid), 32'd0);
      check("t1_trunc",    32'(d0_trunc_stb), 32'd0);
      repeat (15) tick();
      check("t1_gap_end_busy", 32'(d0_busy), 32'd1);
      tick();
      check("t1_idle_busy", 32'(d0_busy), 32'd0);

      // ---------------- round robin over 4 requesters ----------------
      do_reset();
      tx_ready  = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = 32'hA3A2_A1A0;
      for (int m = 0; m < 5; m++) begin
         wait_tx(0, "t2_wait");
         check("t2_grant", 32'(d0_grant_id), 32'(exp_g[m]));
         check("t2_rdy",   32'(d0_req_ready), 32'(1 << exp_g[m]));
         check("t2_data",  32'(d0_tx_data), 32'(8'hA0 + exp_g[m]));
         tick();
         check("t2_msg", 32'(d0_msg_count), 32'(m + 1));
      end
      req_valid = '0;
      req_last  = '0;

      // ---------------- truncation with MAX_BYTES=4 ----------------
      do_reset();
      tx_ready        = 1'b1;
      req_valid       = 4'b0100;
      req_data[23:16] = 8'h10;
      wait_tx(1, "t3_wait");
      check("t3_grant", 32'(d1_grant_id), 32'd2);
      for (int k = 0; k < 4; k++) begin
         check("t3_data", 32'(d1_tx_data), 32'(8'h10 + k));
         check("t3_rdy",  32'(d1_req_ready), 32'b0100);
         tick();
         req_data[23:16] = 8'(8'h11 + k);
         #1;
         if (k < 3) begin
            check("t3_no_trunc", 32'(d1_trunc_stb), 32'd0);
         end
      end
      check("t3_trunc",      32'(d1_trunc_stb), 32'd1);
      check("t3_msg1",       32'(d1_msg_count), 32'd1);
      check("t3_trunc_txv",  32'(d1_tx_valid), 32'd0);
      check("t3_trunc_busy", 32'(d1_busy), 32'd1);
      tick();
      check("t3_trunc_pulse", 32'(d1_trunc_stb), 32'd0);
      wait_tx(1, "t3_wait2");
      check("t3_regrant", 32'(d1_grant_id), 32'd2);
      check("t3_b4",      32'(d1_tx_data), 32'h14);
      tick();
      req_data[23:16] = 8'h15;
      req_last        = 4'b0100;
      #1;
      check("t3_b5", 32'(d1_tx_data), 32'h15);
      tick();
      check("t3_msg2",   32'(d1_msg_count), 32'd2);
      check("t3_trunc2", 32'(d1_trunc_stb), 32'd0);
      // Exactly MAX_BYTES bytes with last on the final one: not a truncation.
      req_last        = '0;
      req_data[23:16] = 8'h20;
      wait_tx(1, "t3_wait3");
      for (int k = 0; k < 4; k++) begin
         req_data[23:16] = 8'(8'h20 + k);
         req_last        = (k == 3) ? 4'b0100 : 4'b0000;
         #1;
         check("t3_lm_data", 32'(d1_tx_data), 32'(8'h20 + k));
         tick();
      end
      check("t3_lastmax_trunc", 32'(d1_trunc_stb), 32'd0);
      check("t3_msg3",          32'(d1_msg_count), 32'd3);
      req_valid = '0;
      req_last  = '0;

      // ---------------- tx_ready back-pressure ----------------
      do_reset();
      tx_ready       = 1'b1;
      req_valid      = 4'b0010;
      req_data[15:8] = 8'h31;
      wait_tx(0, "t4_wait");
      check("t4_grant", 32'(d0_grant_id), 32'd1);
      check("t4_rdy1",  32'(d0_req_ready), 32'b0010);
      tick();                                   // 0x31 accepted
      req_data[15:8] = 8'h32;
      tx_ready       = 1'b0;
      #1;
      check("t4_stall_txv",  32'(d0_tx_valid), 32'd1);
      check("t4_stall_data", 32'(d0_tx_data), 32'h32);
      check("t4_stall_rdy",  32'(d0_req_ready), 32'd0);
      tick();
      check("t4_hold_data", 32'(d0_tx_data), 32'h32);
      check("t4_hold_msg",  32'(d0_msg_count), 32'd0);
      tick();
      tx_ready = 1'b1;
      #1;
      check("t4_rdy_back", 32'(d0_req_ready), 32'b0010);
      check("t4_data_back", 32'(d0_tx_data), 32'h32);
      tick();                                   // 0x32 accepted
      req_data[15:8] = 8'h33;
      req_last       = 4'b0010;
      #1;
      check("t4_b2", 32'(d0_tx_data), 32'h33);
      tick();
      check("t4_msg",     32'(d0_msg_count), 32'd1);
      check("t4_msg_max4", 32'(d1_msg_count), 32'd1);
      check("t4_trunc_max4", 32'(d1_trunc_stb), 32'd0);
      req_valid = '0;
      req_last  = '0;

      // ---------------- reset in the middle of a message ----------------
      req_valid       = 4'b0100;
      req_data[23:16] = 8'h51;
      wait_tx(0, "t5_wait");
      check("t5_grant", 32'(d0_grant_id), 32'd2);
      tick();                                   // byte 1 accepted
      req_data[23:16] = 8'h52;
      rst_n           = 1'b0;
      tick();
      check("t5_busy",  32'(d0_busy), 32'd0);
      check("t5_txv",   32'(d0_tx_valid), 32'd0);
      check("t5_msg",   32'(d0_msg_count), 32'd0);
      check("t5_grant0", 32'(d0_grant_id), 32'd0);
      check("t5_rdy",   32'(d0_req_ready), 32'd0);
      rst_n     = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = 32'hD3D2_D1D0;
      tick();
      check("t5_arb_busy", 32'(d0_busy), 32'd1);
      tick();
      check("t5_rr_grant", 32'(d0_grant_id), 32'd0);
      check("t5_rr_txv",   32'(d0_tx_valid), 32'd1);
      check("t5_rr_data",  32'(d0_tx_data), 32'hD0);
      tick();
      check("t5_rr_msg", 32'(d0_msg_count), 32'd1);
      req_valid = '0;
      req_last  = '0;

      // ---------------- GAP_CYCLES=0 ----------------
      do_reset();
      tx_ready  = 1'b1;
      req_valid = 4'b1010;
      req_last  = 4'b1010;
      req_data  = 32'h6300_6100;
      tick();                                   // ARB
      tick();                                   // XFER, requester 1
      check("t6_grant1", 32'(d2_grant_id), 32'd1);
      check("t6_txv1",   32'(d2_tx_valid), 32'd1);
      check("t6_data1",  32'(d2_tx_data), 32'h61);
      tick();                                   // last handshake -> IDLE
      req_valid = 4'b1000;
      req_last  = 4'b1000;
      check("t6_idle_busy", 32'(d2_busy), 32'd0);
      check("t6_msg1",      32'(d2_msg_count), 32'd1);
      check("t6_idle_txv",  32'(d2_tx_valid), 32'd0);
      tick();
      check("t6_arb_busy", 32'(d2_busy), 32'd1);
      check("t6_arb_txv",  32'(d2_tx_valid), 32'd0);
      tick();
      check("t6_grant3", 32'(d2_grant_id), 32'd3);
      check("t6_txv3",   32'(d2_tx_valid), 32'd1);
      check("t6_data3",  32'(d2_tx_data), 32'h63);
      tick();
      check("t6_msg2",   32'(d2_msg_count), 32'd2);
      check("t6_end_busy", 32'(d2_busy), 32'd0);
      req_valid = '0;
      req_last  = '0;

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin message scheduler that shares one byte-level UART transmitter between NUM_REQ requesters.
- Grants one requester for a whole message, from first byte to last byte, then forwards its bytes to the transmitter with a valid/ready handshake.
- Inserts a fixed idle gap between messages and truncates messages that exceed a maximum length.
- Sits between the firmware/debug message sources and the uart_tx byte engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles enforced after each message (0 = no gap).
- MAX_BYTES, 64, maximum bytes per message before forced truncation (1..65535).
- IDX_W, $clog2(NUM_REQ), width of grant index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8*i+7:8*i].
- req_last  in  NUM_REQ  marks the final byte of a message; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accept.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  byte valid to the transmitter.
- tx_ready  in  1  transmitter accepts byte.
- busy  out  1  high in ARB, XFER and GAP.
- grant_id  out  IDX_W  index of the current or most recent grantee.
- msg_count  out  16  completed or truncated messages; wraps at 16'hFFFF -> 0.
- trunc_stb  out  1  one-cycle pulse when a message is truncated.

Behaviour:
- Clock and reset: all flops on posedge clk. rst_n low forces the following at the next edge, including mid-message:
  - state=IDLE
  - grant_id=0, last_grant=NUM_REQ-1
  - byte_cnt=0, gap_cnt=0
  - msg_count=0, trunc_stb=0
  - req_ready, tx_valid and busy are 0 during and after reset until a grant.
- A byte in flight at reset is dropped. No partial-byte recovery.
- States: IDLE, ARB, XFER, GAP.
- IDLE:
  - If any req_valid is set, go to ARB next cycle.
  - Otherwise stay.
- ARB (1 cycle):
  - Winner is the first set req_valid searching last_grant+1, last_grant+2, ... mod NUM_REQ.
  - Register grant_id=winner and last_grant=winner, clear byte_cnt, go to XFER.
  - If no req_valid remains set, return to IDLE.
- XFER (combinational passthrough, g = grant_id):
  - tx_valid=req_valid[g], tx_data=req_data[g].
  - req_ready[g]=tx_ready. All other req_ready bits are 0.
  - Handshake = req_valid[g] & tx_ready. Each handshake increments byte_cnt.
  - Handshake with req_last[g]=1: msg_count+1, go to GAP (or IDLE if GAP_CYCLES=0).
  - Handshake with byte_cnt reaching MAX_BYTES (that byte is the MAX_BYTES-th) and req_last[g]=0: trunc_stb=1 for one cycle, msg_count+1, go to GAP/IDLE.
    - The requester's remaining bytes form a new message on a later grant.
  - If last and max hit together, last wins: no trunc_stb.
  - req_valid[g] dropping mid-message holds XFER indefinitely. The grant is not released.
- GAP:
  - tx_valid=0, req_ready=0.
  - gap_cnt counts 0..GAP_CYCLES-1, then go to IDLE.
  - Exactly GAP_CYCLES cycles in GAP.
- Latency:
  - req_valid rising in IDLE -> tx_valid high 2 cycles later (IDLE->ARB->XFER).
  - Byte-to-byte throughput inside XFER is 1 per cycle if tx_ready is held high.
- Fairness: a requester that just finished has lowest priority in the next ARB. Requesters holding valid are served in cyclic order.
- grant_id holds its last value outside XFER.

Test Plan:
- Reset, then req_valid=0001, 3 bytes 0x48,0x69,0x0A (last on 0x0A), tx_ready=1 -> tx_valid high 2 cycles after req_valid; tx_data sequence 48,69,0A; msg_count=1; GAP lasts 16 cycles; busy low after.
- All 4 requesters valid, 1-byte messages each -> grant order 0,1,2,3,0; msg_count increments per message; no two requesters ever have req_ready high together.
- MAX_BYTES=4, requester 2 sends 6 bytes with last on byte 6 -> trunc_stb pulses on the 4th handshake; msg_count+1; after GAP, requester 2 re-granted, 2 bytes forwarded, msg_count+1, no trunc_stb.
- tx_ready toggled 1,0,0,1 during XFER -> each byte held stable on tx_data until accepted; req_ready mirrors tx_ready; no byte dropped or duplicated.
- rst_n low for 1 cycle mid-XFER at byte 2 of 5 -> next cycle state IDLE, tx_valid=0, msg_count=0, grant_id=0; next arbitration with all valid grants requester 0.
- GAP_CYCLES=0, requesters 1 and 3 valid -> after requester 1's last handshake the state returns to IDLE immediately; requester 3 tx_valid 2 cycles later.
